// File: rtl/mcu_multicycle_ctrl.sv
// Multi-cycle sequencing controller for the 16-bit MCU datapath: steps each instruction
// through FETCH/DECODE/EXEC/MEM/WB, with run/single-step/halt control and a retire counter.
module mcu_multicycle_ctrl (
  input  logic        clk,
  input  logic        clear,
  input  logic [3:0]  opcode,
  input  logic        eq,
  input  logic        run,
  input  logic        step,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        alu_src,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic [2:0]  alu_op,
  output logic        halted,
  output logic        busy,
  output logic [2:0]  state,
  output logic [15:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALTED = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic        retire;
  logic        in_ex;
  logic        is_rtype, is_addi, is_lw, is_sw, is_bne, is_jmp, is_halt;

  logic        ir_write_q, ir_write_d;
  logic        pc_write_q, pc_write_d;
  logic [1:0]  pc_src_q, pc_src_d;
  logic        bne_exec_q, bne_exec_d;
  logic        reg_write_q, reg_write_d;
  logic        reg_dst_q, reg_dst_d;
  logic        alu_src_q, alu_src_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic        mem_to_reg_q, mem_to_reg_d;
  logic [2:0]  alu_op_q, alu_op_d;
  logic        halted_q, halted_d;
  logic        busy_q, busy_d;
  logic [15:0] instr_count_q, instr_count_d;

  assign is_rtype = ~opcode[3];
  assign is_addi  = (opcode == 4'h8);
  assign is_lw    = (opcode == 4'h9);
  assign is_sw    = (opcode == 4'hA);
  assign is_bne   = (opcode == 4'hB);
  assign is_jmp   = (opcode == 4'hC);
  assign is_halt  = (opcode == 4'hD);

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_IDLE:   if (run || step) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (is_rtype || is_addi)  state_d = S_WB;
        else if (is_lw || is_sw)  state_d = S_MEM;
        else                      retire  = 1'b1;
      end
      S_MEM: begin
        if (is_lw) state_d = S_WB;
        else       retire  = 1'b1;
      end
      S_WB:     retire  = 1'b1;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
    if (retire) begin
      if (state_q == S_EXEC && is_halt) state_d = S_HALTED;
      else                              state_d = run ? S_FETCH : S_IDLE;
    end
  end

  // Outputs are computed for the state being entered; the IR is stable from DECODE on,
  // so EXEC-phase selects can be decoded one cycle early and held through MEM/WB.
  always_comb begin
    in_ex         = (state_d == S_EXEC) || (state_d == S_MEM) || (state_d == S_WB);
    ir_write_d    = (state_d == S_FETCH);
    pc_write_d    = (state_d == S_FETCH) || (state_d == S_EXEC && is_jmp);
    bne_exec_d    = (state_d == S_EXEC) && is_bne;
    pc_src_d      = 2'd0;
    if (state_d == S_EXEC && is_jmp)      pc_src_d = 2'd2;
    else if (state_d == S_EXEC && is_bne) pc_src_d = 2'd1;
    reg_write_d   = (state_d == S_WB);
    mem_read_d    = (state_d == S_MEM) && is_lw;
    mem_write_d   = (state_d == S_MEM) && is_sw;
    alu_src_d     = in_ex && (is_addi || is_lw || is_sw);
    reg_dst_d     = in_ex && is_rtype;
    mem_to_reg_d  = in_ex && is_lw;
    alu_op_d      = 3'b000;
    if (in_ex && is_rtype)    alu_op_d = opcode[2:0];
    else if (in_ex && is_bne) alu_op_d = 3'b001;
    halted_d      = (state_d == S_HALTED);
    busy_d        = (state_d != S_IDLE) && (state_d != S_HALTED);
    instr_count_d = instr_count_q + {15'd0, retire};
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q       <= S_IDLE;
      ir_write_q    <= 1'b0;
      pc_write_q    <= 1'b0;
      pc_src_q      <= 2'd0;
      bne_exec_q    <= 1'b0;
      reg_write_q   <= 1'b0;
      reg_dst_q     <= 1'b0;
      alu_src_q     <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_to_reg_q  <= 1'b0;
      alu_op_q      <= 3'b000;
      halted_q      <= 1'b0;
      busy_q        <= 1'b0;
      instr_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      ir_write_q    <= ir_write_d;
      pc_write_q    <= pc_write_d;
      pc_src_q      <= pc_src_d;
      bne_exec_q    <= bne_exec_d;
      reg_write_q   <= reg_write_d;
      reg_dst_q     <= reg_dst_d;
      alu_src_q     <= alu_src_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_to_reg_q  <= mem_to_reg_d;
      alu_op_q      <= alu_op_d;
      halted_q      <= halted_d;
      busy_q        <= busy_d;
      instr_count_q <= instr_count_d;
    end
  end

  // The branch-taken PC load is the one path that sees eq combinationally.
  assign pc_write    = pc_write_q | (bne_exec_q & ~eq);
  assign ir_write    = ir_write_q;
  assign pc_src      = pc_src_q;
  assign reg_write   = reg_write_q;
  assign reg_dst     = reg_dst_q;
  assign alu_src     = alu_src_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_to_reg  = mem_to_reg_q;
  assign alu_op      = alu_op_q;
  assign halted      = halted_q;
  assign busy        = busy_q;
  assign state       = state_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_mcu_multicycle_ctrl.sv
// Scoreboard bench for mcu_multicycle_ctrl: each scenario pushes per-cycle expected
// output vectors, a monitor pops and compares them just before each falling edge.
module tb_mcu_multicycle_ctrl;

  typedef struct packed {
    logic [2:0]  st;
    logic        irw;
    logic        pcw;
    logic [1:0]  pcs;
    logic        rw;
    logic        rd;
    logic        as;
    logic        mr;
    logic        mw;
    logic        m2r;
    logic [2:0]  aop;
    logic        hlt;
    logic        bsy;
    logic [15:0] cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        clear, eq, run, step;
  logic [3:0]  opcode;
  logic        ir_write, pc_write, reg_write, reg_dst, alu_src;
  logic        mem_read, mem_write, mem_to_reg, halted, busy;
  logic [1:0]  pc_src;
  logic [2:0]  alu_op, state;
  logic [15:0] instr_count;

  int          total = 0;
  int          bad = 0;
  int          mw_pulses = 0;
  logic [15:0] exp_cnt = 16'd0;
  vec_t        exp_q[$];
  vec_t        obs;

  mcu_multicycle_ctrl dut (
    .clk(clk), .clear(clear), .opcode(opcode), .eq(eq), .run(run), .step(step),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
    .reg_dst(reg_dst), .alu_src(alu_src), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .alu_op(alu_op), .halted(halted), .busy(busy),
    .state(state), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  assign obs = {state, ir_write, pc_write, pc_src, reg_write, reg_dst, alu_src,
                mem_read, mem_write, mem_to_reg, alu_op, halted, busy, instr_count};

  always @(posedge clk) begin
    vec_t e;
    #4;
    if (mem_write) mw_pulses++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL cycle_outputs t=%0t state=%0d got=%h expected=%h", $time, state, obs, e);
      end else begin
        $display("ok   cycle_outputs t=%0t state=%0d vec=%h", $time, state, obs);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  function automatic vec_t reset_vec();
    vec_t v;
    v = '0;
    return v;
  endfunction

  task automatic do_clear();
    exp_q.push_back(reset_vec());
    clear = 1'b1;
    run   = 1'b0;
    step  = 1'b0;
    @(negedge clk);
    clear   = 1'b0;
    exp_cnt = 16'd0;
  endtask

  task automatic idle_cycles(input int n);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v = '0;
      v.cnt = exp_cnt;
      exp_q.push_back(v);
      @(negedge clk);
    end
  endtask

  // Caller leaves the DUT about to enter FETCH at the next rising edge.
  task automatic do_instr(input logic [3:0] op, input logic e, input logic run_last,
                          input logic step_mid, input int stop);
    vec_t v;
    int   n_full, n, base;
    logic rt, ad, lw, sw, bn, jp, has_mem, has_wb;
    rt = ~op[3]; ad = (op == 4'h8); lw = (op == 4'h9); sw = (op == 4'hA);
    bn = (op == 4'hB); jp = (op == 4'hC);
    has_mem = lw | sw;
    has_wb  = rt | ad | lw;
    n_full  = 3 + (has_mem ? 1 : 0) + (has_wb ? 1 : 0);
    n       = (stop > 0 && stop < n_full) ? stop : n_full;
    base    = exp_q.size();
    v = '0; v.bsy = 1'b1; v.cnt = exp_cnt;
    v.st = 3'd1; v.irw = 1'b1; v.pcw = 1'b1;
    exp_q.push_back(v);
    v.st = 3'd2; v.irw = 1'b0; v.pcw = 1'b0;
    exp_q.push_back(v);
    v.st  = 3'd3;
    v.rd  = rt;
    v.as  = ad | lw | sw;
    v.m2r = lw;
    v.aop = rt ? op[2:0] : (bn ? 3'b001 : 3'b000);
    v.pcw = jp | (bn & ~e);
    v.pcs = jp ? 2'd2 : (bn ? 2'd1 : 2'd0);
    exp_q.push_back(v);
    v.pcw = 1'b0; v.pcs = 2'd0;
    if (has_mem) begin
      v.st = 3'd4; v.mr = lw; v.mw = sw;
      exp_q.push_back(v);
      v.mr = 1'b0; v.mw = 1'b0;
    end
    if (has_wb) begin
      v.st = 3'd5; v.rw = 1'b1;
      exp_q.push_back(v);
    end
    while (exp_q.size() > base + n) void'(exp_q.pop_back());
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      step = step_mid && (i == 1);
      if (i >= 1) opcode = op;
      eq = e;
      if (i == n_full - 1) run = run_last;
    end
    if (n == n_full) exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic test_reset();
    clear = 1'b1; run = 1'b0; step = 1'b0; eq = 1'b0; opcode = 4'h0;
    exp_q.push_back(reset_vec());
    @(negedge clk);
    run = 1'b1; step = 1'b1;
    exp_q.push_back(reset_vec());
    @(negedge clk);
    total++;
    if (state !== 3'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL clear_priority got state=%0d busy=%b expected state=0 busy=0", state, busy);
    end
    clear = 1'b0; run = 1'b0; step = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_rtype();
    do_clear();
    run = 1'b1;
    do_instr(4'h0, 1'b0, 1'b0, 1'b0, 0);
    idle_cycles(1);
    total++;
    if (instr_count !== 16'd1) begin
      bad++;
      $display("FAIL add_count got=%0d expected=1", instr_count);
    end
    run = 1'b1;
    do_instr(4'h6, 1'b0, 1'b1, 1'b0, 0);
    do_instr(4'h8, 1'b0, 1'b0, 1'b0, 0);
    idle_cycles(1);
  endtask

  task automatic test_lw_sw();
    do_clear();
    mw_pulses = 0;
    run = 1'b1;
    do_instr(4'h9, 1'b0, 1'b1, 1'b0, 0);
    do_instr(4'hA, 1'b0, 1'b0, 1'b0, 0);
    idle_cycles(1);
    total++;
    if (mw_pulses !== 1 || instr_count !== 16'd2) begin
      bad++;
      $display("FAIL lw_sw got mem_write_cycles=%0d count=%0d expected 1 and 2", mw_pulses, instr_count);
    end
  endtask

  task automatic test_branch_jump();
    do_clear();
    run = 1'b1;
    do_instr(4'hB, 1'b0, 1'b1, 1'b0, 0);
    do_instr(4'hB, 1'b1, 1'b1, 1'b0, 0);
    do_instr(4'hC, 1'b0, 1'b1, 1'b0, 0);
    do_instr(4'hF, 1'b0, 1'b0, 1'b0, 0);
    idle_cycles(1);
  endtask

  task automatic test_back_to_back_step();
    do_clear();
    step = 1'b1;
    do_instr(4'h1, 1'b0, 1'b0, 1'b1, 0);
    idle_cycles(2);
    step = 1'b1;
    do_instr(4'h8, 1'b0, 1'b0, 1'b0, 0);
    idle_cycles(2);
    total++;
    if (instr_count !== 16'd2 || state !== 3'd0) begin
      bad++;
      $display("FAIL step_count got count=%0d state=%0d expected 2 and 0", instr_count, state);
    end
  endtask

  task automatic test_halt();
    vec_t v;
    do_clear();
    run = 1'b1;
    do_instr(4'hD, 1'b0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      v = '0; v.st = 3'd6; v.hlt = 1'b1; v.cnt = exp_cnt;
      exp_q.push_back(v);
      run  = 1'($urandom_range(0, 1));
      step = (i % 2 == 0);
      @(negedge clk);
    end
    total++;
    if (halted !== 1'b1 || state !== 3'd6) begin
      bad++;
      $display("FAIL halt_hold got halted=%b state=%0d expected 1 and 6", halted, state);
    end
    do_clear();
    total++;
    if (halted !== 1'b0 || instr_count !== 16'd0) begin
      bad++;
      $display("FAIL halt_clear got halted=%b count=%0d expected 0 and 0", halted, instr_count);
    end
  endtask

  task automatic test_clear_mem();
    do_clear();
    run = 1'b1;
    do_instr(4'hA, 1'b0, 1'b1, 1'b0, 3);
    mw_pulses = 0;
    clear = 1'b1;
    exp_q.push_back(reset_vec());
    @(negedge clk);
    clear = 1'b0; run = 1'b0;
    idle_cycles(1);
    total++;
    if (mw_pulses !== 0) begin
      bad++;
      $display("FAIL clear_in_sw got mem_write_cycles=%0d expected 0", mw_pulses);
    end
  endtask

  task automatic test_count_wrap();
    do_clear();
    force dut.instr_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.instr_count_q;
    exp_cnt = 16'hFFFF;
    idle_cycles(1);
    step = 1'b1;
    do_instr(4'hE, 1'b0, 1'b0, 1'b0, 0);
    idle_cycles(1);
    total++;
    if (instr_count !== 16'h0000) begin
      bad++;
      $display("FAIL count_wrap got=%h expected=0000", instr_count);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_sw();
    test_branch_jump();
    test_back_to_back_step();
    test_halt();
    test_clear_mem();
    test_count_wrap();
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d pending expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
